// File: rtl/clic_pkg.sv
// clic_pkg: shared trigger encoding and default sizing for the CLIC gateway.
package clic_pkg;
  typedef enum logic [1:0] {POS_LEVEL, POS_EDGE, NEG_LEVEL, NEG_EDGE} trig_e;
  localparam int N_SOURCE_DFLT = 32;
  localparam int SRC_ID_W = $clog2(N_SOURCE_DFLT);
endpackage

// File: rtl/clic_gateway_if.sv
// clic_gateway_if: interrupt lines, trigger attributes, sw pending, ack and pending outputs.
interface clic_gateway_if #(
  parameter int N_SOURCE = 32,
  parameter int ID_W = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
);
  logic [N_SOURCE-1:0] irq_src_i;
  logic [N_SOURCE-1:0] edge_i;
  logic [N_SOURCE-1:0] pol_i;
  logic [N_SOURCE-1:0] ie_i;
  logic [N_SOURCE-1:0] ip_sw_i;
  logic [N_SOURCE-1:0] ip_sw_we_i;
  logic                ack_valid_i;
  logic [ID_W-1:0]     ack_id_i;
  logic [N_SOURCE-1:0] ip_o;
  logic [N_SOURCE-1:0] ipe_o;
  logic                any_o;
  modport master (
    output irq_src_i, edge_i, pol_i, ie_i, ip_sw_i, ip_sw_we_i, ack_valid_i, ack_id_i,
    input  ip_o, ipe_o, any_o
  );
  modport slave (
    input  irq_src_i, edge_i, pol_i, ie_i, ip_sw_i, ip_sw_we_i, ack_valid_i, ack_id_i,
    output ip_o, ipe_o, any_o
  );
endinterface

// File: rtl/clic_gateway_cell.sv
// clic_gateway_cell: one source - synchroniser, polarity, edge/level capture of the pending bit.
module clic_gateway_cell import clic_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  src,
  input  trig_e trig,
  input  logic  armed,
  input  logic  sw,
  input  logic  sw_we,
  input  logic  ack_hit,
  output logic  ip
);
  logic synced, s, prev_q, rise, is_edge, nxt;
  if (SYNC_STAGES == 0) begin : g_bypass
    assign synced = src;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else begin
        sync_q[0] <= src;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign synced = sync_q[SYNC_STAGES-1];
  end
  assign is_edge = trig inside {POS_EDGE, NEG_EDGE};
  assign s = synced ^ (trig inside {NEG_LEVEL, NEG_EDGE});
  assign rise = s & ~prev_q & armed;
  // A rise outranks sw writes and acks so no edge is ever dropped.
  always_comb nxt = !is_edge ? s : rise ? 1'b1 : sw_we ? sw : ack_hit ? 1'b0 : ip;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      ip     <= 1'b0;
    end else begin
      prev_q <= s;
      ip     <= nxt;
    end
  end
endmodule

// File: rtl/clic_gateway.sv
// clic_gateway: per-source interrupt gateway producing the hardware pending vector.
module clic_gateway import clic_pkg::*; #(
  parameter int N_SOURCE    = N_SOURCE_DFLT,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  clic_gateway_if.slave bus
);
  logic armed_q;
  // Held low for one cycle after reset so inverted-polarity sources do not fake an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) armed_q <= 1'b0;
    else armed_q <= 1'b1;
  end
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    clic_gateway_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk     (clk_i),
      .rst     (rst_i),
      .src     (bus.irq_src_i[i]),
      .trig    (trig_e'({bus.pol_i[i], bus.edge_i[i]})),
      .armed   (armed_q),
      .sw      (bus.ip_sw_i[i]),
      .sw_we   (bus.ip_sw_we_i[i]),
      .ack_hit (bus.ack_valid_i && (int'(bus.ack_id_i) == i)),
      .ip      (bus.ip_o[i])
    );
  end
  assign bus.ipe_o = bus.ip_o & bus.ie_i;
  assign bus.any_o = |bus.ipe_o;
endmodule

// File: tb/tb_clic_gateway.sv
// tb_clic_gateway: directed scenarios plus randomized traffic against a behavioural pending model.
module tb_clic_gateway;
  localparam int N = 24;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  clic_gateway_if #(.N_SOURCE(N)) bus ();
  clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(SYNC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  // Model: the source seen by capture is the raw line from SYNC clock edges ago, xor polarity.
  logic [N-1:0] m_ip, m_prev;
  bit m_armed;
  logic [N-1:0] srcq[$];
  always @(posedge clk or posedge rst) begin
    logic [N-1:0] s, ack_vec;
    if (rst) begin
      m_ip = '0;
      m_prev = '0;
      m_armed = 0;
      srcq.delete();
      for (int k = 0; k < SYNC; k++) srcq.push_back('0);
    end else begin
      s = srcq[0] ^ bus.pol_i;
      ack_vec = '0;
      if (bus.ack_valid_i && int'(bus.ack_id_i) < N) ack_vec[bus.ack_id_i] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!bus.edge_i[i]) m_ip[i] = s[i];
        else if (s[i] && !m_prev[i] && m_armed) m_ip[i] = 1'b1;
        else if (bus.ip_sw_we_i[i]) m_ip[i] = bus.ip_sw_i[i];
        else if (ack_vec[i]) m_ip[i] = 1'b0;
      end
      m_prev = s;
      m_armed = 1;
      srcq.push_back(bus.irq_src_i);
      void'(srcq.pop_front());
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ip_o", 32'(bus.ip_o), 32'(m_ip));
      chk("ipe_o", 32'(bus.ipe_o), 32'(m_ip & bus.ie_i));
      chk("any_o", 32'(bus.any_o), 32'(|(m_ip & bus.ie_i)));
    end
  endtask

  initial begin
    bus.irq_src_i = '0; bus.edge_i = '0; bus.pol_i = '0; bus.ie_i = '0;
    bus.ip_sw_i = '0; bus.ip_sw_we_i = '0; bus.ack_valid_i = 1'b0; bus.ack_id_i = '0;
    step(2);
    chk("reset_ip", 32'(bus.ip_o), 0);
    chk("reset_any", 32'(bus.any_o), 0);
    rst = 1'b0;
    // Level source: sw writes and acks on the same source are ignored.
    bus.irq_src_i[3] = 1'b1; bus.ip_sw_we_i = '1; bus.ack_valid_i = 1'b1; bus.ack_id_i = 5'd3;
    step(2);
    chk("lvl_before", 32'(bus.ip_o[3]), 0);
    step(1);
    chk("lvl_rise", 32'(bus.ip_o[3]), 1);
    step(2);
    bus.irq_src_i[3] = 1'b0;
    step(2);
    chk("lvl_hold", 32'(bus.ip_o[3]), 1);
    step(1);
    chk("lvl_fall", 32'(bus.ip_o[3]), 0);
    bus.ip_sw_we_i = '0; bus.ack_valid_i = 1'b0;
    // Edge pulse captured, then acked.
    bus.edge_i[5] = 1'b1; bus.irq_src_i[5] = 1'b1;
    step(1);
    bus.irq_src_i[5] = 1'b0;
    step(2);
    chk("edge_cap", 32'(bus.ip_o[5]), 1);
    step(3);
    chk("edge_sticky", 32'(bus.ip_o[5]), 1);
    bus.ack_valid_i = 1'b1; bus.ack_id_i = 5'd5;
    step(1);
    bus.ack_valid_i = 1'b0;
    chk("edge_ack", 32'(bus.ip_o[5]), 0);
    // Rise coinciding with ack, then with a software clear.
    bus.edge_i[7] = 1'b1; bus.irq_src_i[7] = 1'b1;
    step(2);
    bus.ack_valid_i = 1'b1; bus.ack_id_i = 5'd7;
    step(1);
    bus.ack_valid_i = 1'b0;
    chk("rise_vs_ack", 32'(bus.ip_o[7]), 1);
    bus.ack_valid_i = 1'b1;
    step(1);
    bus.ack_valid_i = 1'b0;
    chk("ack_clear7", 32'(bus.ip_o[7]), 0);
    bus.irq_src_i[7] = 1'b0;
    step(3);
    bus.irq_src_i[7] = 1'b1;
    step(2);
    bus.ip_sw_we_i[7] = 1'b1; bus.ip_sw_i[7] = 1'b0;
    step(1);
    bus.ip_sw_we_i[7] = 1'b0;
    chk("rise_vs_sw", 32'(bus.ip_o[7]), 1);
    bus.ip_sw_we_i[7] = 1'b1;
    step(1);
    bus.ip_sw_we_i[7] = 1'b0;
    chk("sw_clear7", 32'(bus.ip_o[7]), 0);
    // Active-low sources held idle through reset release.
    bus.irq_src_i = '0; rst = 1'b1; bus.pol_i = '1; bus.edge_i[9] = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    chk("neg_edge_armed", 32'(bus.ip_o[9]), 0);
    chk("neg_level", 32'(bus.ip_o[10]), 1);
    bus.pol_i = '0;
    step(3);
    // Enable gating.
    bus.edge_i = '1; bus.ip_sw_we_i = '1; bus.ip_sw_i = 24'h10; bus.ie_i = '0;
    step(1);
    bus.ip_sw_we_i = '0; bus.ip_sw_i = '0;
    chk("ie_ip", 32'(bus.ip_o), 32'h10);
    chk("ie_ipe0", 32'(bus.ipe_o), 0);
    chk("ie_any0", 32'(bus.any_o), 0);
    bus.ie_i[4] = 1'b1;
    #1;
    chk("ie_any1", 32'(bus.any_o), 1);
    chk("ie_ipe1", 32'(bus.ipe_o), 32'h10);
    // Out-of-range acks.
    bus.ack_valid_i = 1'b1; bus.ack_id_i = 5'd24;
    step(1);
    chk("ack_oor24", 32'(bus.ip_o), 32'h10);
    bus.ack_id_i = 5'd31;
    step(1);
    bus.ack_valid_i = 1'b0;
    chk("ack_oor31", 32'(bus.ip_o), 32'h10);
    // Asynchronous reset while pending.
    rst = 1'b1;
    #1;
    chk("async_rst_ip", 32'(bus.ip_o), 0);
    chk("async_rst_any", 32'(bus.any_o), 0);
    step(1);
    rst = 1'b0;
    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.irq_src_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : bus.irq_src_i ^ (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) bus.edge_i = N'($urandom);
      if ($urandom_range(0, 31) == 0) bus.pol_i = N'($urandom);
      bus.ie_i = N'($urandom);
      bus.ip_sw_i = N'($urandom);
      bus.ip_sw_we_i = N'($urandom) & N'($urandom) & N'($urandom);
      bus.ack_valid_i = 1'($urandom);
      bus.ack_id_i = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
